// File: rtl/cl_ocl_axil_rr_master_if.sv
// AXI-Lite master/slave signal bundle used by the round-robin register master.
// Data is fixed at 32 bits with 4 byte strobes; only the address width is parameterised.
interface cl_ocl_axil_rr_master_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/cl_ocl_axil_rr_master.sv
// Round-robin scheduler sharing one AXI-Lite master port between N_REQ requesters.
// One transaction outstanding at a time; each requester sees a req/done handshake.
module cl_ocl_axil_rr_master #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                    clk_main_a0,
    input  logic                    rst_main,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*32-1:0]     req_wdata,
    input  logic [N_REQ*4-1:0]      req_wstrb,
    output logic [N_REQ-1:0]        done,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    cl_ocl_axil_rr_master_if.master m
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_RESP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               arvalid_q, arvalid_d;
    logic               bready_q, bready_d;
    logic               rready_q, rready_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               aw_fire;
    logic               w_fire;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        bready_d   = bready_q;
        rready_d   = rready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        done_d     = '0;
        rdata_d    = rdata_q;
        err_d      = err_q;

        aw_fire = awvalid_q & m.awready;
        w_fire  = wvalid_q & m.wready;

        // Scan starts just after the previous winner so every requester gets a turn.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!sel_found && req[IDX_W'((32'(last_gnt_q) + i) % N_REQ)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((32'(last_gnt_q) + i) % N_REQ);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d      = sel_idx;
                    last_gnt_d = sel_idx;
                    wr_d       = req_wr[sel_idx];
                    addr_d     = req_addr[sel_idx*ADDR_W +: ADDR_W];
                    wdata_d    = req_wdata[sel_idx*32 +: 32];
                    wstrb_d    = req_wstrb[sel_idx*4 +: 4];
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    if (req_wr[sel_idx]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (wr_q) begin
                    if (aw_fire) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end
                    if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
                        bready_d = 1'b1;
                        state_d  = S_RESP;
                    end
                end else if (arvalid_q & m.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (wr_q & bready_q & m.bvalid) begin
                    err_d         = |m.bresp;
                    rdata_d       = '0;
                    bready_d      = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    state_d       = S_DONE;
                end else if (!wr_q & rready_q & m.rvalid) begin
                    err_d         = |m.rresp;
                    rdata_d       = m.rdata;
                    rready_d      = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state_q    <= S_IDLE;
            last_gnt_q <= IDX_W'(N_REQ - 1);
            gnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            done_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            bready_q   <= bready_d;
            rready_q   <= rready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign done      = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign m.awvalid = awvalid_q;
    assign m.awaddr  = addr_q;
    assign m.wvalid  = wvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.bready  = bready_q;
    assign m.arvalid = arvalid_q;
    assign m.araddr  = addr_q;
    assign m.rready  = rready_q;
endmodule

// File: tb/tb_cl_ocl_axil_rr_master.sv
// Directed plus randomized bench for the round-robin AXI-Lite master (three requesters).
// The slave side is driven cycle by cycle; expected grants come from a round-robin model.
module tb_cl_ocl_axil_rr_master;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N*4-1:0]  req_wstrb;
    logic [N-1:0]    done;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;

    logic            f_wr[N];
    logic [31:0]     f_addr[N];
    logic [31:0]     f_wdata[N];
    logic [3:0]      f_wstrb[N];
    bit              cont[N];

    int n_checks = 0;
    int n_pass   = 0;
    int last_g;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_wr[i]              = f_wr[i];
            req_addr[i*AW +: AW]   = f_addr[i];
            req_wdata[i*32 +: 32]  = f_wdata[i];
            req_wstrb[i*4 +: 4]    = f_wstrb[i];
        end
    end

    cl_ocl_axil_rr_master_if #(.ADDR_W(AW)) bus ();

    cl_ocl_axil_rr_master #(.N_REQ(N), .ADDR_W(AW)) dut (
        .clk_main_a0 (clk),
        .rst_main    (rst),
        .req         (req),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .done        (done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .m           (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_fields(input int i);
        f_wr[i]    = 1'($urandom_range(0, 1));
        f_addr[i]  = $urandom();
        f_wdata[i] = $urandom();
        f_wstrb[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_awvalid"}, bus.awvalid, 0);
        check({tag, "_wvalid"},  bus.wvalid,  0);
        check({tag, "_arvalid"}, bus.arvalid, 0);
    endtask

    // Call at a negedge where the DUT sits in IDLE and req already shows requester g as winner.
    task automatic serve(input int g, input int ad, input int wd, input int rspd,
                         input logic [1:0] resp, input logic [31:0] rd, input bit drop);
        logic        ewr    = f_wr[g];
        logic [31:0] eaddr  = f_addr[g];
        logic [31:0] ewdata = f_wdata[g];
        logic [3:0]  ewstrb = f_wstrb[g];
        logic [N-1:0] exp_done;
        int mx;
        last_g = g;
        @(negedge clk);
        rand_fields(g);
        if (drop) req[g] = 1'b0;
        if (ewr) begin
            mx = (ad > wd) ? ad : wd;
            for (int c = 0; c <= mx; c++) begin
                check("addr_awvalid", bus.awvalid, 64'(c <= ad));
                check("addr_wvalid",  bus.wvalid,  64'(c <= wd));
                if (bus.awvalid) check("awaddr", bus.awaddr, eaddr);
                if (bus.wvalid) begin
                    check("wdata", bus.wdata, ewdata);
                    check("wstrb", bus.wstrb, ewstrb);
                end
                check("addr_arvalid", bus.arvalid, 0);
                check("addr_bready",  bus.bready,  0);
                check("addr_done",    done,        0);
                bus.awready = (c == ad);
                bus.wready  = (c == wd);
                @(negedge clk);
                bus.awready = 1'b0;
                bus.wready  = 1'b0;
            end
            for (int c = 0; c <= rspd; c++) begin
                check("resp_awvalid", bus.awvalid, 0);
                check("resp_wvalid",  bus.wvalid,  0);
                check("resp_bready",  bus.bready,  1);
                check("resp_done",    done,        0);
                bus.bvalid = (c == rspd);
                bus.bresp  = resp;
                @(negedge clk);
                bus.bvalid = 1'b0;
            end
        end else begin
            for (int c = 0; c <= ad; c++) begin
                check("addr_arvalid", bus.arvalid, 1);
                check("araddr",       bus.araddr,  eaddr);
                check("addr_awvalid", bus.awvalid, 0);
                check("addr_rready",  bus.rready,  0);
                check("addr_done",    done,        0);
                bus.arready = (c == ad);
                @(negedge clk);
                bus.arready = 1'b0;
            end
            for (int c = 0; c <= rspd; c++) begin
                check("resp_arvalid", bus.arvalid, 0);
                check("resp_rready",  bus.rready,  1);
                check("resp_done",    done,        0);
                bus.rvalid = (c == rspd);
                bus.rdata  = (c == rspd) ? rd : $urandom();
                bus.rresp  = resp;
                @(negedge clk);
                bus.rvalid = 1'b0;
            end
        end
        exp_done    = '0;
        exp_done[g] = 1'b1;
        check("done_onehot", done, exp_done);
        check("rsp_err",   rsp_err,   64'(resp != 2'd0));
        check("rsp_rdata", rsp_rdata, ewr ? 32'd0 : rd);
        check("done_bready", bus.bready, 0);
        check("done_rready", bus.rready, 0);
        if (!cont[g]) req[g] = 1'b0;
        @(negedge clk);
        check("idle_done", done, 0);
        check_idle_bus("idle");
        check("hold_rdata", rsp_rdata, ewr ? 32'd0 : rd);
        check("hold_err",   rsp_err,   64'(resp != 2'd0));
    endtask

    initial begin
        int g;
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin
            f_wr[i] = 1'b0; f_addr[i] = '0; f_wdata[i] = '0; f_wstrb[i] = '0; cont[i] = 1'b0;
        end
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'd0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'd0;

        repeat (2) @(negedge clk);
        check_idle_bus("rst");
        check("rst_bready", bus.bready, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_done",   done,       0);
        check("rst_rdata",  rsp_rdata,  0);
        check("rst_err",    rsp_err,    0);
        rst = 1'b0;
        last_g = N - 1;

        // T1: reset in the middle of ADDR drops awvalid immediately
        f_wr[0] = 1'b1; f_addr[0] = 32'h500; f_wdata[0] = 32'hDEADBEEF; f_wstrb[0] = 4'hF;
        req = 3'b001;
        @(negedge clk);
        check("t1_awvalid", bus.awvalid, 1);
        @(negedge clk);
        check("t1_awvalid_hold", bus.awvalid, 1);
        check("t1_awaddr", bus.awaddr, 32'h500);
        #2 rst = 1'b1;
        #1;
        check("t1_async_awvalid", bus.awvalid, 0);
        check("t1_async_wvalid",  bus.wvalid,  0);
        check("t1_async_done",    done,        0);
        @(negedge clk);
        check("t1_rst_done", done, 0);
        rst = 1'b0;
        last_g = N - 1;
        f_wr[1] = 1'b0; f_addr[1] = 32'h504; f_wdata[1] = '0; f_wstrb[1] = '0;
        req = 3'b011;

        // T2: zero-wait write from req0 wins first arbitration after reset
        g = pick(req, last_g);
        serve(0, 0, 0, 0, 2'd0, 32'd0, 1'b0);

        // T3: read from req1 with slow AR and SLVERR response
        serve(1, 3, 0, 2, 2'd2, 32'h0000ABCD, 1'b0);

        // T4: write data accepted well before address
        rand_fields(2);
        f_wr[2] = 1'b1;
        req = 3'b100;
        serve(2, 4, 0, 1, 2'd0, 32'd0, 1'b0);

        // T5: two continuous requesters alternate starting at req0
        rand_fields(0);
        rand_fields(1);
        req = 3'b011;
        begin
            int order[6] = '{0, 1, 0, 1, 0, 1};
            for (int k = 0; k < 6; k++) begin
                cont[order[k]] = (k < 4);
                serve(order[k], 0, 0, 0, 2'd0, $urandom(), 1'b0);
            end
        end
        cont[0] = 1'b0;
        cont[1] = 1'b0;

        // T6: req dropped right after grant still completes, no re-grant
        rand_fields(0);
        f_wr[0] = 1'b1;
        req = 3'b001;
        serve(0, 1, 2, 1, 2'd0, 32'd0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_idle_bus("t6_no_regrant");
        end

        // Randomized traffic against the round-robin model
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    rand_fields(i);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                g = $urandom_range(0, N - 1);
                rand_fields(g);
                req[g] = 1'b1;
            end
            g = pick(req, last_g);
            cont[g] = 1'($urandom_range(0, 1));
            serve(g, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  2'($urandom_range(0, 3)), $urandom(), $urandom_range(0, 4) == 0);
        end
        for (int i = 0; i < N; i++) cont[i] = 1'b0;
        while (req != '0) begin
            g = pick(req, last_g);
            serve(g, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                  2'($urandom_range(0, 3)), $urandom(), 1'b0);
        end
        @(negedge clk);
        check_idle_bus("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
